// File: rtl/rx_frame_assembler.sv
// Serial receive front-end: recovers one start/data/stop framed word from rx_in
// and hands it to decode_logic through a valid/ack buffer.
module rx_frame_assembler #(
   parameter int unsigned FRAME_W = 55,
   parameter int unsigned CNT_W   = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rx_in,
   input  logic               bit_tick,
   input  logic               rx_ack,
   output logic [FRAME_W-1:0] RX_Data,
   output logic               rx_valid,
   output logic               framing_err,
   output logic               overrun,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

   state_t             state;
   logic [FRAME_W-1:0] shreg;
   logic [CNT_W-1:0]   count;

   // Receive FSM, output buffer and one-cycle status pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         shreg       <= '0;
         count       <= '0;
         RX_Data     <= '0;
         rx_valid    <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         framing_err <= 1'b0;
         overrun     <= 1'b0;

         if (rx_ack && rx_valid) begin
            rx_valid <= 1'b0;
         end

         if (bit_tick) begin
            unique case (state)
               IDLE: begin
                  if (!rx_in) begin
                     state <= DATA;
                     count <= '0;
                     busy  <= 1'b1;
                  end
               end
               DATA: begin
                  shreg <= {shreg[FRAME_W-2:0], rx_in};
                  count <= count + CNT_W'(1);
                  if (count == LAST_BIT) begin
                     state <= STOP;
                  end
               end
               STOP: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (rx_in) begin
                     // A same-cycle ack frees the buffer, so the new frame wins.
                     if (!rx_valid || rx_ack) begin
                        RX_Data  <= shreg;
                        rx_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     framing_err <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Directed bench for rx_frame_assembler: frames are serialised onto rx_in and a
// negedge monitor pops the expected frame whenever a new word is loaded.
module tb_rx_frame_assembler;

   localparam int unsigned FRAME_W = 55;
   localparam int unsigned CNT_W   = 6;

   logic               clk;
   logic               rst_n;
   logic               rx_in;
   logic               bit_tick;
   logic               rx_ack;
   logic [FRAME_W-1:0] RX_Data;
   logic               rx_valid;
   logic               framing_err;
   logic               overrun;
   logic               busy;

   rx_frame_assembler #(.FRAME_W(FRAME_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .bit_tick(bit_tick), .rx_ack(rx_ack),
      .RX_Data(RX_Data), .rx_valid(rx_valid), .framing_err(framing_err),
      .overrun(overrun), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned        n_cmp = 0;
   int unsigned        n_err = 0;
   logic [FRAME_W-1:0] exp_q[$];
   bit                 model_valid = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: a rise of rx_valid, or new data while valid, is a load.
   logic               prev_valid = 1'b0;
   logic [FRAME_W-1:0] prev_data  = '0;
   logic               prev_fe    = 1'b0;
   logic               prev_ov    = 1'b0;
   always @(negedge clk) begin
      if (rx_valid && (!prev_valid || RX_Data !== prev_data)) begin
         chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) chk("sb_frame", 64'(RX_Data), 64'(exp_q.pop_front()));
      end
      if (framing_err) chk("fe_one_clk", 64'(prev_fe), 64'd0);
      if (overrun)     chk("ov_one_clk", 64'(prev_ov), 64'd0);
      prev_valid = rx_valid;
      prev_data  = RX_Data;
      prev_fe    = framing_err;
      prev_ov    = overrun;
   end

   task automatic clk_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b, input logic ack);
      rx_in    = b;
      bit_tick = 1'b1;
      rx_ack   = ack;
      clk_n(1);
      bit_tick = 1'b0;
      rx_ack   = 1'b0;
   endtask

   task automatic send_frame(input logic [FRAME_W-1:0] f, input logic stop,
                             input logic ack_stop, input int gap_at);
      bit exp_load;
      bit exp_ov;
      bit exp_v;
      exp_load = stop && (!model_valid || ack_stop);
      exp_ov   = stop && model_valid && !ack_stop;
      exp_v    = exp_load ? 1'b1 : (ack_stop ? 1'b0 : model_valid);
      send_bit(1'b0, 1'b0);
      chk("busy_after_start", 64'(busy), 64'd1);
      clk_n(3);
      for (int i = 0; i < int'(FRAME_W); i++) begin
         if (i == gap_at) begin
            repeat (50) begin
               rx_in = 1'($urandom);
               clk_n(1);
            end
         end
         send_bit(f[FRAME_W-1-i], 1'b0);
         clk_n(3);
      end
      if (exp_load) exp_q.push_back(f);
      send_bit(stop, ack_stop);
      chk("valid_after_stop", 64'(rx_valid), 64'(exp_v));
      chk("busy_after_stop", 64'(busy), 64'd0);
      chk("overrun_pulse", 64'(overrun), 64'(exp_ov));
      chk("framing_pulse", 64'(framing_err), 64'(!stop));
      model_valid = exp_v;
      rx_in = 1'b1;
      clk_n(1);
      chk("pulses_cleared", 64'({overrun, framing_err}), 64'd0);
      clk_n(2);
   endtask

   task automatic do_ack();
      rx_ack = 1'b1;
      clk_n(1);
      rx_ack = 1'b0;
      model_valid = 1'b0;
      chk("valid_after_ack", 64'(rx_valid), 64'd0);
   endtask

   initial begin
      logic [FRAME_W-1:0] f1;
      logic [FRAME_W-1:0] fa;
      logic [FRAME_W-1:0] fb;
      logic [FRAME_W-1:0] fr;
      bit                 any_pulse;

      f1 = {3'b010, 4'hA, 48'h0123456789AB};
      fa = {3'b001, 4'h3, 48'h1};
      fb = {3'b001, 4'h3, 48'h2};

      rst_n = 1'b0; rx_in = 1'b1; bit_tick = 1'b0; rx_ack = 1'b0;
      clk_n(2);
      rst_n = 1'b1;
      chk("reset_data", 64'(RX_Data), 64'd0);
      chk("reset_flags", 64'({rx_valid, framing_err, overrun, busy}), 64'd0);

      // Idle line: no start bit ever seen.
      any_pulse = 1'b0;
      for (int i = 0; i < 100; i++) begin
         send_bit(1'b1, 1'b0);
         if (framing_err || overrun || busy || rx_valid) any_pulse = 1'b1;
         clk_n(3);
      end
      chk("idle_quiet", 64'(any_pulse), 64'd0);
      chk("idle_data", 64'(RX_Data), 64'd0);

      // Good frame, field decode and hold-until-ack.
      send_frame(f1, 1'b1, 1'b0, -1);
      chk("type_field", 64'(RX_Data[54:52]), 64'd2);
      chk("addr_field", 64'(RX_Data[51:48]), 64'hA);
      chk("raw_field", 64'(RX_Data[47:0]), 64'h0123456789AB);
      clk_n(10);
      chk("hold_valid", 64'(rx_valid), 64'd1);
      chk("hold_data", 64'(RX_Data), 64'(f1));
      do_ack();
      do_ack();
      chk("ack_idle_data", 64'(RX_Data), 64'(f1));

      // Framing error, then recovery.
      send_frame(f1, 1'b0, 1'b0, -1);
      chk("fe_no_valid", 64'(rx_valid), 64'd0);
      send_frame(f1, 1'b1, 1'b0, -1);
      do_ack();

      // Overrun, then simultaneous ack and load.
      send_frame(fa, 1'b1, 1'b0, -1);
      send_frame(fb, 1'b1, 1'b0, -1);
      chk("overrun_keeps", 64'(RX_Data), 64'(fa));
      send_frame(fb, 1'b1, 1'b1, -1);
      chk("ack_load_data", 64'(RX_Data), 64'(fb));
      chk("ack_load_valid", 64'(rx_valid), 64'd1);
      do_ack();

      // Reset mid-frame with a buffered frame pending.
      send_frame(fa, 1'b1, 1'b0, -1);
      send_bit(1'b0, 1'b0);
      clk_n(3);
      for (int i = 0; i < 20; i++) begin
         send_bit(1'b1, 1'b0);
         clk_n(3);
      end
      rst_n = 1'b0;
      clk_n(1);
      rst_n = 1'b1;
      model_valid = 1'b0;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_valid", 64'(rx_valid), 64'd0);
      chk("midrst_data", 64'(RX_Data), 64'd0);
      clk_n(3);
      send_frame(55'h7FFFFFFFFFFFFF, 1'b1, 1'b0, -1);
      chk("all_ones", 64'(RX_Data), 64'h7FFFFFFFFFFFFF);
      do_ack();

      // Tick gating with noise on the line mid-frame.
      fr = 55'({$urandom, $urandom});
      send_frame(fr, 1'b1, 1'b0, 30);
      chk("gap_frame", 64'(RX_Data), 64'(fr));
      do_ack();

      clk_n(4);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
